comma_aligner: RTL and testbench
================================

COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 Parameter LOCK_COUNT, default 3: number of commas at the same offset required to declare lock.
REQ-002 Parameter LOSS_COUNT, default 2: number of consecutive commas at a non-active offset required to drop lock.
REQ-003 BitCLK_10  input  1  word-rate clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset, sampled on the BitCLK_10 rising edge.
REQ-005 RxUnaligned_10  input  10  raw deserializer word with arbitrary bit slip; bit 9 = first received bit (a).
REQ-006 RxParallel_10  output  10  realigned 10-bit code group for the 8b/10b decoder; bit 9 = bit a.
REQ-007 RxCommaDet  output  1  high for one cycle, coincident with RxParallel_10 carrying a comma-bearing code group.
REQ-008 RxAligned  output  1  high while the state is LOCKED.

Function
REQ-009 The block shall register each input word as prev_q and form a 20-bit window {prev_q, RxUnaligned_10}; window bit 19 is the oldest bit.
REQ-010 Candidate at offset k (0..9) shall be window[19-k : 10-k].
REQ-011 A candidate shall be a comma when its bits [9:3] equal 7'b0011111 or 7'b1100000.
REQ-012 When several offsets match in one window, the active offset shall take priority; otherwise the lowest k shall be used.
REQ-013 The state machine shall have three states: UNLOCKED, CANDIDATE and LOCKED.
REQ-014 UNLOCKED, comma at k: offset<=k, cnt<=1, go to CANDIDATE; with no comma, hold.
REQ-015 CANDIDATE, comma at active offset: cnt<=cnt+1; when the incremented cnt equals LOCK_COUNT, go to LOCKED.
REQ-016 CANDIDATE, comma only at another offset k: offset<=k, cnt<=1, stay in CANDIDATE; with no comma, hold.
REQ-017 LOCKED, comma at active offset: miss<=0.
REQ-018 LOCKED, comma only at another offset: miss<=miss+1; when miss reaches LOSS_COUNT, go to UNLOCKED with offset held; with no comma, hold.
REQ-019 Every edge shall register RxParallel_10 <= the candidate at the offset in effect after this edge's update (realignment applies immediately).
REQ-020 Latency: a code group whose first bit sits at offset k shall appear on RxParallel_10 exactly 2 edges after that first bit is presented on RxUnaligned_10.
REQ-021 RxCommaDet shall be registered as 1 exactly when the candidate loaded into RxParallel_10 is a comma.
REQ-022 RxAligned shall be registered and shall rise on the same edge the state enters LOCKED.
REQ-023 RxAligned shall fall on the same edge the state leaves LOCKED.
REQ-024 cnt and miss shall saturate and never wrap.

Reset
REQ-025 While Reset=0 at an edge: state<=UNLOCKED, offset<=0, cnt<=0, miss<=0, prev_q<=0, RxParallel_10<=0, RxCommaDet<=0, RxAligned<=0.
REQ-026 Reset asserted mid-lock shall take precedence over all other events in that cycle.

Structure
REQ-027 Comma patterns, the state encoding, and the LOCK_COUNT/LOSS_COUNT defaults shall live in the shared package serdes_pkg.
REQ-028 The combinational window search shall be a sub-module comma_search (inputs: window, active offset; outputs: found, found_offset, active_hit).
REQ-029 State, counters and output registers shall reside in comma_aligner.

Verification
REQ-030 Reset -> all outputs 0 during and after reset until the first comma is processed; assert Reset during LOCKED -> RxAligned=0 on the next edge.
REQ-031 Offset 0 lock: drive 0011111010, 1001010101, 0011111010, 1001010101, 0011111010 -> RxAligned rises on the edge processing the third comma, and RxParallel_10 reproduces the stream 2 edges late with RxCommaDet on the comma words.
REQ-032 Slip 3 (stream delayed by 3 bits) -> offset=3 and RxParallel_10 carries the unshifted code groups after lock.
REQ-033 Disparity: alternating K28.5 0011111010 and 1100000101 -> both detected and lock achieved.
REQ-034 Spurious comma: while LOCKED at offset 0, one comma at offset 5, then a comma at offset 0 -> lock is retained and miss returns to 0.
REQ-035 Realign: while LOCKED at offset 0, two consecutive commas at offset 5 -> RxAligned falls on the second; three further commas at offset 5 -> relock at offset 5.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared SERDES definitions: comma patterns, aligner state encoding,
// default lock/loss thresholds and small window helpers.
// Latency: none (types/functions only). Backpressure: n/a.
package serdes_pkg;

  // Default thresholds for the comma aligner.
  localparam int LOCK_COUNT_DEF = 3;
  localparam int LOSS_COUNT_DEF = 2;

  // 7-bit comma prefixes (bits [9:3] of a code group, bit 9 = bit a).
  localparam logic [6:0] COMMA_POS = 7'b0011111;
  localparam logic [6:0] COMMA_NEG = 7'b1100000;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_LOCKED    = 2'd2
  } align_state_e;

  function automatic logic is_comma(input logic [9:0] cg);
    return (cg[9:3] == COMMA_POS) || (cg[9:3] == COMMA_NEG);
  endfunction

  // Candidate at offset k of a 20-bit window is window[19-k : 10-k].
  function automatic logic [9:0] window_slice(input logic [19:0] win,
                                              input logic [3:0]  k);
    logic [19:0] sh;
    sh = win << k;
    return sh[19:10];
  endfunction

endpackage

// File: rtl/comma_aligner_if.sv
// Word bus between deserializer, comma aligner and 8b/10b decoder.
// Ports: RxUnaligned_10 (raw word in), RxParallel_10 / RxCommaDet / RxAligned (out).
// Latency: n/a (wires only). Backpressure: none, one word every clock.
interface comma_aligner_if;
  logic [9:0] RxUnaligned_10;
  logic [9:0] RxParallel_10;
  logic       RxCommaDet;
  logic       RxAligned;

  // master: the side feeding raw words and consuming aligned output
  modport master (
    output RxUnaligned_10,
    input  RxParallel_10,
    input  RxCommaDet,
    input  RxAligned
  );

  // slave: the aligner itself
  modport slave (
    input  RxUnaligned_10,
    output RxParallel_10,
    output RxCommaDet,
    output RxAligned
  );
endinterface

// File: rtl/comma_search.sv
// Combinational comma search over all ten bit offsets of a 20-bit window.
// Ports: window_i, active_off_i in; found_o, found_off_o (lowest k), active_hit_o out.
// Latency: 0 cycles (pure combinational). Backpressure: none.
module comma_search
  import serdes_pkg::*;
(
  input  logic [19:0] window_i,
  input  logic [3:0]  active_off_i,
  output logic        found_o,
  output logic [3:0]  found_off_o,
  output logic        active_hit_o
);

  always_comb begin
    found_o     = 1'b0;
    found_off_o = 4'd0;
    // Scan from the highest offset down so the lowest matching k wins.
    for (int k = 9; k >= 0; k--) begin
      if (is_comma(window_slice(window_i, 4'(k)))) begin
        found_o     = 1'b1;
        found_off_o = 4'(k);
      end
    end
    active_hit_o = is_comma(window_slice(window_i, active_off_i));
  end

endmodule

// File: rtl/comma_aligner.sv
// 10-bit comma aligner: finds the comma bit offset, locks after LOCK_COUNT hits, realigns words.
// Ports: BitCLK_10 (word clock), Reset (sync active-low), bus (comma_aligner_if.slave).
// Latency: 2 edges from first bit of a code group to RxParallel_10. Backpressure: none.
module comma_aligner
  import serdes_pkg::*;
#(
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int LOSS_COUNT = LOSS_COUNT_DEF
) (
  input  logic            BitCLK_10,
  input  logic            Reset,
  comma_aligner_if.slave  bus
);

  localparam int CNT_W  = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = (LOSS_COUNT < 2) ? 1 : $clog2(LOSS_COUNT + 1);

  align_state_e      state_q, state_d;
  logic [3:0]        offset_q, offset_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [9:0]        prev_q;
  logic [9:0]        par_q, par_d;
  logic              det_q, det_d;
  logic              aligned_q, aligned_d;

  logic [19:0] window;
  logic        found;
  logic [3:0]  found_off;
  logic        active_hit;
  logic [3:0]  sel_off;

  // Oldest bit is window[19]: previous word then current word.
  assign window = {prev_q, bus.RxUnaligned_10};

  comma_search u_search (
    .window_i     (window),
    .active_off_i (offset_q),
    .found_o      (found),
    .found_off_o  (found_off),
    .active_hit_o (active_hit)
  );

  // The active offset wins over any other offset matching in the same window.
  assign sel_off = active_hit ? offset_q : found_off;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_d    = cnt_q;
    miss_d   = miss_q;

    unique case (state_q)
      ST_UNLOCKED: begin
        if (found) begin
          offset_d = sel_off;
          cnt_d    = CNT_W'(1);
          if (LOCK_COUNT <= 1) begin
            state_d = ST_LOCKED;
            miss_d  = '0;
          end else begin
            state_d = ST_CANDIDATE;
          end
        end
      end

      ST_CANDIDATE: begin
        if (active_hit) begin
          if (int'(cnt_q) + 1 >= LOCK_COUNT) begin
            cnt_d   = CNT_W'(LOCK_COUNT);
            state_d = ST_LOCKED;
            // Start each lock period with a clean miss history.
            miss_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (found) begin
          offset_d = found_off;
          cnt_d    = CNT_W'(1);
        end
      end

      ST_LOCKED: begin
        if (active_hit) begin
          miss_d = '0;
        end else if (found) begin
          if (int'(miss_q) + 1 >= LOSS_COUNT) begin
            // Offset is deliberately kept; the next comma re-seeds it.
            miss_d  = MISS_W'(LOSS_COUNT);
            state_d = ST_UNLOCKED;
          end else begin
            miss_d = miss_q + MISS_W'(1);
          end
        end
      end

      default: state_d = ST_UNLOCKED;
    endcase

    // Output uses the offset chosen on this very edge, so realignment is immediate.
    par_d     = window_slice(window, offset_d);
    det_d     = is_comma(par_d);
    aligned_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge BitCLK_10) begin
    if (!Reset) begin
      state_q   <= ST_UNLOCKED;
      offset_q  <= 4'd0;
      cnt_q     <= '0;
      miss_q    <= '0;
      prev_q    <= 10'd0;
      par_q     <= 10'd0;
      det_q     <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      cnt_q     <= cnt_d;
      miss_q    <= miss_d;
      prev_q    <= bus.RxUnaligned_10;
      par_q     <= par_d;
      det_q     <= det_d;
      aligned_q <= aligned_d;
    end
  end

  assign bus.RxParallel_10 = par_q;
  assign bus.RxCommaDet    = det_q;
  assign bus.RxAligned     = aligned_q;

endmodule

// File: tb/tb_comma_aligner.sv
// Bench for comma_aligner: directed word vectors with hand-computed outputs.
// Clock 10 time units; inputs driven 1 unit after the rising edge, outputs sampled there too.
module tb_comma_aligner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  comma_aligner_if u_if ();

  comma_aligner #(
    .LOCK_COUNT (3),
    .LOSS_COUNT (2)
  ) dut (
    .BitCLK_10 (clk),
    .Reset     (rst_n),
    .bus       (u_if.slave)
  );

  always #5 clk = ~clk;

  // Code groups and hand-built shifted words.
  localparam logic [9:0] C = 10'b0011111010; // K28.5 RD-
  localparam logic [9:0] N = 10'b1100000101; // K28.5 RD+
  localparam logic [9:0] D = 10'b1001010101; // filler data group
  localparam logic [9:0] X = 10'b1010100111; // {D[4:0], C[9:5]}
  localparam logic [9:0] Y = 10'b1101010101; // {C[4:0], 10101}
  localparam logic [9:0] P = 10'b1101010010; // {C[4:0], D[9:5]}
  localparam logic [9:0] Q = 10'b1010011111; // {D[2:0], C[9:3]}
  localparam logic [9:0] R = 10'b0101001010; // {C[2:0], D[9:3]}

  typedef struct {
    logic       rst_n;
    logic [9:0] din;
    logic [9:0] par;
    logic       det;
    logic       al;
    int         off;   // -1 = not checked
    int         miss;  // -1 = not checked
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(logic r, logic [9:0] d, logic [9:0] p, logic dt,
                              logic a, int o, int m);
    vec_t v;
    v.rst_n = r; v.din = d; v.par = p; v.det = dt; v.al = a; v.off = o; v.miss = m;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic [9:0] d);
    rst_n = r;
    u_if.RxUnaligned_10 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(string tag, logic [9:0] p, logic dt, logic a);
    check({tag, " par"}, int'(u_if.RxParallel_10), int'(p));
    check({tag, " det"}, int'(u_if.RxCommaDet), int'(dt));
    check({tag, " aligned"}, int'(u_if.RxAligned), int'(a));
  endtask

  initial begin
    u_if.RxUnaligned_10 = 10'd0;

    // ---- offset-0 lock, spurious comma, realign to offset 5, reset mid-lock
    add(0, 0, 0, 0, 0, 0, 0);   // 0 reset
    add(1, 0, 0, 0, 0, 0, 0);   // 1
    add(1, C, 0, 0, 0, 0, 0);   // 2 comma presented
    add(1, D, C, 1, 0, 0, -1);  // 3 cnt=1
    add(1, C, D, 0, 0, 0, -1);  // 4
    add(1, D, C, 1, 0, 0, -1);  // 5 cnt=2
    add(1, C, D, 0, 0, 0, -1);  // 6
    add(1, D, C, 1, 1, 0, 0);   // 7 third comma -> LOCKED
    add(1, C, D, 0, 1, 0, -1);  // 8
    add(1, D, C, 1, 1, 0, 0);   // 9
    add(1, X, D, 0, 1, 0, 0);   // 10
    add(1, Y, X, 0, 1, 0, 1);   // 11 spurious comma at offset 5
    add(1, C, Y, 0, 1, 0, 1);   // 12
    add(1, D, C, 1, 1, 0, 0);   // 13 comma at active offset clears miss
    add(1, X, D, 0, 1, 0, 0);   // 14
    add(1, Y, X, 0, 1, 0, 1);   // 15 second lone spurious comma keeps lock
    add(1, C, Y, 0, 1, 0, 1);   // 16
    add(1, D, C, 1, 1, 0, 0);   // 17
    add(1, X, D, 0, 1, 0, 0);   // 18 stream now slipped by 5
    add(1, P, X, 0, 1, 0, 1);   // 19 comma at 5, miss=1
    add(1, X, P, 0, 1, 0, 1);   // 20
    add(1, P, X, 0, 0, 0, -1);  // 21 second comma at 5 -> UNLOCKED, offset held
    add(1, X, P, 0, 0, 0, -1);  // 22
    add(1, P, C, 1, 0, 5, -1);  // 23 CANDIDATE at 5, realigned at once
    add(1, X, D, 0, 0, 5, -1);  // 24
    add(1, P, C, 1, 0, 5, -1);  // 25
    add(1, X, D, 0, 0, 5, -1);  // 26
    add(1, P, C, 1, 1, 5, -1);  // 27 relock at 5
    add(1, X, D, 0, 1, 5, -1);  // 28
    add(1, P, C, 1, 1, 5, -1);  // 29
    add(0, C, 0, 0, 0, 0, 0);   // 30 reset while LOCKED wins over comma
    // ---- disparity: alternating RD- / RD+ K28.5
    add(1, C, 0, 0, 0, 0, -1);  // 31
    add(1, N, C, 1, 0, 0, -1);  // 32
    add(1, C, N, 1, 0, 0, -1);  // 33
    add(1, N, C, 1, 1, 0, -1);  // 34
    add(1, C, N, 1, 1, 0, -1);  // 35
    // ---- stream slipped by 3 bits
    add(0, 0, 0, 0, 0, 0, 0);   // 36 reset
    add(1, Q, 0, 0, 0, 0, -1);  // 37
    add(1, R, C, 1, 0, 3, -1);  // 38
    add(1, Q, D, 0, 0, 3, -1);  // 39
    add(1, R, C, 1, 0, 3, -1);  // 40
    add(1, Q, D, 0, 0, 3, -1);  // 41
    add(1, R, C, 1, 1, 3, -1);  // 42
    add(1, Q, D, 0, 1, 3, -1);  // 43
    add(1, R, C, 1, 1, 3, -1);  // 44

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].rst_n, vecs[i].din);
      check_outs(tag, vecs[i].par, vecs[i].det, vecs[i].al);
      if (vecs[i].off >= 0)
        check({tag, " offset"}, int'(dut.offset_q), vecs[i].off);
      if (vecs[i].miss >= 0)
        check({tag, " miss"}, int'(dut.miss_q), vecs[i].miss);
    end

    // Reset held across several edges while commas stream in: outputs stay 0.
    step(0, C);
    check_outs("rst_hold0", 10'd0, 1'b0, 1'b0);
    step(0, D);
    check_outs("rst_hold1", 10'd0, 1'b0, 1'b0);
    step(0, C);
    check_outs("rst_hold2", 10'd0, 1'b0, 1'b0);
    // Comma presented during reset is dropped; a fresh one appears 2 edges later.
    step(1, C);
    check_outs("post_rst0", 10'd0, 1'b0, 1'b0);
    step(1, D);
    check_outs("post_rst1", C, 1'b1, 1'b0);
    check("post_rst1 state", int'(dut.state_q), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
